// File: rtl/cp0_unit_pkg.sv
// CP0 shared definitions: register addresses, SR/Cause field positions, exception vector.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: register map addresses, SR/Cause bit positions, exception vector,
//           helpers that assemble the architectural read views of SR and Cause.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    // The next-PC logic steers here on interrupt entry; kept beside CP0 so both agree.
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    // SR as seen by mfc0: only IM, EXL and IE exist, everything else reads 0.
    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] r;
        r                = '0;
        r[IM_HI:IM_LO]   = im;
        r[EXL_BIT]       = exl;
        r[IE_BIT]        = ie;
        return r;
    endfunction

    // Cause as seen by mfc0: only the IP field exists.
    function automatic logic [31:0] pack_cause(input logic [5:0] ip);
        logic [31:0] r;
        r              = '0;
        r[IM_HI:IM_LO] = ip;
        return r;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// CP0 datapath/controller bundle: mfc0/mtc0 traffic, interrupt lines, EXL control, results.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain per-cycle level.
// Ports: A1 read addr, A2/DIn/We mtc0 write, PC resume addr, HWInt lines,
//        EXLSet/EXLClr entry/return strobes; IntReq, EPC, DOut returned by CP0.
interface cp0_unit_if;
    import cp0_unit_pkg::*;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic [5:0]  HWInt;
    logic        EXLSet;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    // Datapath/controller side.
    modport master (
        output A1, A2, DIn, We, PC, HWInt, EXLSet, EXLClr,
        input  IntReq, EPC, DOut
    );

    // CP0 side.
    modport slave (
        input  A1, A2, DIn, We, PC, HWInt, EXLSet, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_unit.sv
// CP0: SR/Cause/EPC/PrID registers, interrupt sampling and request, EPC capture and eret.
// Latency: register updates visible 1 cycle after the edge; DOut/IntReq/EPC are combinational from state.
// Backpressure: none; every mtc0/EXLSet/EXLClr is accepted in the cycle it is presented.
// Ports: clk, reset (async, active-high), bus (cp0_unit_if.slave) carrying
//        A1/DOut read, A2/DIn/We write, PC, HWInt, EXLSet, EXLClr, IntReq, EPC.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic         clk,
    input  logic         reset,
    cp0_unit_if.slave    bus
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic [5:0]  cause_ip;
    logic [31:2] epc_q;

    logic sr_wr;
    logic epc_wr;

    assign sr_wr  = bus.We && (bus.A2 == CP0_SR);
    assign epc_wr = bus.We && (bus.A2 == CP0_EPC);

    // SR. Interrupt entry wins outright: a coincident mtc0 to SR is discarded in
    // full so the handler starts with the mask state that was live at entry.
    // eret alongside an mtc0 keeps the written IM/IE but still forces EXL low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im  <= '0;
            sr_exl <= 1'b0;
            sr_ie  <= 1'b0;
        end else if (bus.EXLSet) begin
            sr_exl <= 1'b1;
        end else if (sr_wr) begin
            sr_im  <= bus.DIn[IM_HI:IM_LO];
            sr_ie  <= bus.DIn[IE_BIT];
            sr_exl <= bus.EXLClr ? 1'b0 : bus.DIn[EXL_BIT];
        end else if (bus.EXLClr) begin
            sr_exl <= 1'b0;
        end
    end

    // Cause.IP is a free-running one-stage sample of the lines; this register is
    // what keeps HWInt off any combinational path to IntReq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_ip <= '0;
        end else begin
            cause_ip <= bus.HWInt;
        end
    end

    // EPC holds a word address; the low two bits are never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q <= '0;
        end else if (bus.EXLSet) begin
            epc_q <= bus.PC[31:2];
        end else if (epc_wr) begin
            epc_q <= bus.DIn[31:2];
        end
    end

    // PC[1:0] is deliberately dropped on capture.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^bus.PC[1:0];

    assign bus.IntReq = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    assign bus.EPC    = {epc_q, 2'b00};

    // Reads see current state only; a same-cycle write lands at the next edge.
    assign bus.DOut = (bus.A1 == CP0_SR)    ? pack_sr(sr_im, sr_exl, sr_ie) :
                      (bus.A1 == CP0_CAUSE) ? pack_cause(cause_ip)          :
                      (bus.A1 == CP0_EPC)   ? {epc_q, 2'b00}                :
                      (bus.A1 == CP0_PRID)  ? PRID                          :
                                              32'h0000_0000;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
// Latency: inputs applied 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: n/a.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    cp0_unit_if bus ();

    cp0_unit #(.PRID(32'h4D49_5053)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.We     = 1'b0;
        bus.A2     = 5'd0;
        bus.DIn    = 32'h0;
        bus.EXLSet = 1'b0;
        bus.EXLClr = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [4];
        logic [31:0] exp   [4];
        addrs = '{5'd12, 5'd13, 5'd14, 5'd15};
        exp   = '{32'h0, 32'h0, 32'h0, 32'h4D49_5053};
        reset = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            bus.A1 = addrs[i];
            #1;
            tests++;
            if (bus.DOut !== exp[i]) begin
                failed++;
                $display("FAIL reset_read a=%0d got=%h exp=%h", addrs[i], bus.DOut, exp[i]);
            end
        end
        tests++;
        if (bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL reset_intreq got=%b exp=0", bus.IntReq);
        end
        tests++;
        if (bus.EPC !== 32'h0) begin
            failed++;
            $display("FAIL reset_epc got=%h exp=0", bus.EPC);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_interrupt_raise();
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        cycle();
        idle_inputs();
        bus.A1 = 5'd12;
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_0401 || bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL raise_sr_write sr=%h intreq=%b exp sr=00000401 intreq=0",
                     bus.DOut, bus.IntReq);
        end
        bus.HWInt = 6'b000001;
        #1;
        tests++;
        if (bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL raise_no_comb_path got=%b exp=0", bus.IntReq);
        end
        cycle();
        bus.A1 = 5'd13;
        #1;
        tests++;
        if (bus.IntReq !== 1'b1 || bus.DOut !== 32'h0000_0400) begin
            failed++;
            $display("FAIL raise_one_cycle intreq=%b cause=%h exp intreq=1 cause=00000400",
                     bus.IntReq, bus.DOut);
        end
    endtask

    task automatic test_entry_return();
        bus.EXLSet = 1'b1; bus.PC = 32'h0000_3017;
        cycle();
        idle_inputs();
        bus.A1 = 5'd12;
        #1;
        tests++;
        if (bus.EPC !== 32'h0000_3014 || bus.DOut !== 32'h0000_0403 || bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL entry epc=%h sr=%h intreq=%b exp epc=00003014 sr=00000403 intreq=0",
                     bus.EPC, bus.DOut, bus.IntReq);
        end
        bus.A1 = 5'd14;
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_3014) begin
            failed++;
            $display("FAIL entry_epc_read got=%h exp=00003014", bus.DOut);
        end
        bus.EXLClr = 1'b1;
        cycle();
        idle_inputs();
        bus.A1 = 5'd12;
        #1;
        tests++;
        if (bus.IntReq !== 1'b1 || bus.EPC !== 32'h0000_3014 || bus.DOut !== 32'h0000_0401) begin
            failed++;
            $display("FAIL eret intreq=%b epc=%h sr=%h exp intreq=1 epc=00003014 sr=00000401",
                     bus.IntReq, bus.EPC, bus.DOut);
        end
    endtask

    task automatic test_simultaneous();
        bus.EXLSet = 1'b1; bus.EXLClr = 1'b1; bus.PC = 32'h0000_3100;
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hDEAD_BEEF;
        cycle();
        idle_inputs();
        bus.A1 = 5'd12;
        #1;
        tests++;
        if (bus.EPC !== 32'h0000_3100 || bus.DOut !== 32'h0000_0403 || bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL set_clr_we epc=%h sr=%h intreq=%b exp epc=00003100 sr=00000403 intreq=0",
                     bus.EPC, bus.DOut, bus.IntReq);
        end
        // mtc0 SR alongside entry is dropped in full.
        bus.EXLSet = 1'b1; bus.PC = 32'h0000_3100;
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0000;
        cycle();
        idle_inputs();
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_0403) begin
            failed++;
            $display("FAIL set_drops_sr_write got=%h exp=00000403", bus.DOut);
        end
        // eret alongside mtc0 SR: written fields apply, EXL forced low.
        bus.EXLClr = 1'b1;
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
        cycle();
        idle_inputs();
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_0401 || bus.IntReq !== 1'b1) begin
            failed++;
            $display("FAIL clr_with_sr_write sr=%h intreq=%b exp sr=00000401 intreq=1",
                     bus.DOut, bus.IntReq);
        end
    endtask

    task automatic test_masking();
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_7C01;
        bus.HWInt = 6'b100000;
        cycle();
        idle_inputs();
        cycle();
        bus.A1 = 5'd13;
        #1;
        tests++;
        if (bus.IntReq !== 1'b0 || bus.DOut !== 32'h0000_8000) begin
            failed++;
            $display("FAIL masked intreq=%b cause=%h exp intreq=0 cause=00008000",
                     bus.IntReq, bus.DOut);
        end
        bus.We = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
        cycle();
        idle_inputs();
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_8000) begin
            failed++;
            $display("FAIL cause_readonly got=%h exp=00008000", bus.DOut);
        end
        bus.We = 1'b1; bus.A2 = 5'd7; bus.DIn = 32'hFFFF_FFFF;
        bus.HWInt = 6'b000001;
        cycle();
        idle_inputs();
        bus.A1 = 5'd7;
        #1;
        tests++;
        if (bus.DOut !== 32'h0 || bus.IntReq !== 1'b1) begin
            failed++;
            $display("FAIL unmapped rd7=%h intreq=%b exp rd7=00000000 intreq=1",
                     bus.DOut, bus.IntReq);
        end
        bus.A1 = 5'd12;
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_7C01) begin
            failed++;
            $display("FAIL sr_untouched got=%h exp=00007C01", bus.DOut);
        end
        bus.HWInt = 6'b000000;
        cycle();
        tests++;
        if (bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL hwint_fall got=%b exp=0", bus.IntReq);
        end
    endtask

    task automatic test_async_reset();
        // Pending interrupt plus a nonzero EPC; the read during the write sees the old EPC.
        bus.HWInt = 6'b000001;
        bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_1237;
        bus.A1 = 5'd14;
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_3100) begin
            failed++;
            $display("FAIL no_bypass got=%h exp=00003100", bus.DOut);
        end
        cycle();
        idle_inputs();
        tests++;
        if (bus.IntReq !== 1'b1 || bus.EPC !== 32'h0000_1234) begin
            failed++;
            $display("FAIL pre_reset intreq=%b epc=%h exp intreq=1 epc=00001234",
                     bus.IntReq, bus.EPC);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.IntReq !== 1'b0 || bus.EPC !== 32'h0) begin
            failed++;
            $display("FAIL async_reset_pending intreq=%b epc=%h exp intreq=0 epc=00000000",
                     bus.IntReq, bus.EPC);
        end
        reset = 1'b0;
        cycle();
        // Now with EXL set inside a handler.
        bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        cycle();
        idle_inputs();
        bus.EXLSet = 1'b1; bus.PC = 32'h0000_0050;
        cycle();
        idle_inputs();
        bus.A1 = 5'd12;
        #1;
        tests++;
        if (bus.DOut !== 32'h0000_0403 || bus.EPC !== 32'h0000_0050) begin
            failed++;
            $display("FAIL pre_reset_exl sr=%h epc=%h exp sr=00000403 epc=00000050",
                     bus.DOut, bus.EPC);
        end
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.DOut !== 32'h0 || bus.EPC !== 32'h0 || bus.IntReq !== 1'b0) begin
            failed++;
            $display("FAIL async_reset_exl sr=%h epc=%h intreq=%b exp all zero",
                     bus.DOut, bus.EPC, bus.IntReq);
        end
        cycle();
        bus.A1 = 5'd13;
        #1;
        tests++;
        if (bus.DOut !== 32'h0) begin
            failed++;
            $display("FAIL cause_held_in_reset got=%h exp=00000000", bus.DOut);
        end
        reset = 1'b0;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b1;
        bus.A1    = 5'd0;
        bus.PC    = 32'h0;
        bus.HWInt = 6'b0;
        idle_inputs();

        test_reset();
        test_interrupt_raise();
        test_entry_return();
        test_simultaneous();
        test_masking();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

System coprocessor (CP0) for the MIPS core: holds SR, Cause, EPC and PrID, samples hardware interrupt lines, and raises the interrupt request that drives the next-PC `intr` selection. On interrupt entry it captures the resume address into EPC. On `eret` it clears EXL and supplies EPC to the next-PC logic. It sits beside the register file in the execute/memory region and serves `mfc0`/`mtc0` traffic from the datapath.

## Interface

**Parameters**
- `PRID`, default 32'h4D495053: constant value returned by PrID (reg 15).

**Ports**
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `A1`  in  5: `mfc0` read address (rd field).
- `A2`  in  5: `mtc0` write address (rd field).
- `DIn`  in  32: `mtc0` write data.
- `We`  in  1: `mtc0` write enable.
- `PC`  in  32: resume address to save on interrupt entry.
- `HWInt`  in  6: hardware interrupt lines. Level-sensitive and synchronous to `clk`.
- `EXLSet`  in  1: interrupt accepted this cycle (controller asserts together with `intr`).
- `EXLClr`  in  1: `eret` executing this cycle.
- `IntReq`  out  1: interrupt request to the controller.
- `EPC`  out  32: current EPC register, wired to the next-PC `EPC` input.
- `DOut`  out  32: `mfc0` read data.

## Operation

**Register map**
- **SR (12)**: IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
- **Cause (13)**: IP = [15:10]. All other bits read 0. Read-only.
- **EPC (14)**: 32 bits, with bits [1:0] always 0.
- **PrID (15)**: returns `PRID`.
- **Any other address**: reads 0; writes are ignored.

**Interrupt sampling and request**
- Cause.IP <= `HWInt` every cycle, unconditionally.
- `IntReq` = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
- `IntReq` is combinational from registered state only. It has no direct path from `HWInt`.

**Interrupt entry (`EXLSet`=1)**
- SR.EXL <= 1.
- EPC <= {`PC`[31:2], 2'b00}.

**Interrupt return (`EXLClr`=1)**
- SR.EXL <= 0.
- EPC is unchanged.

**`mtc0` (`We`=1)**
- `A2`=12: IM, EXL and IE take the corresponding `DIn` bits.
- `A2`=14: EPC <= {`DIn`[31:2], 2'b00}.
- `A2`=13 or 15: no effect.

**Read**
- `DOut` is combinational from `A1` and the current register contents.
- There is no write bypass: a read in the same cycle as a write to the same register returns the old value.

**Priority on simultaneous events**
- `EXLSet` beats `EXLClr` on the EXL bit.
- `EXLSet` beats `We`: an `mtc0` to SR or EPC in the same cycle is dropped entirely, all fields.
- `EXLClr` + `We` to SR: the written fields apply, except that EXL <= 0.
- Cause.IP updates regardless of every other input.

## Timing

**Reset values**
- SR, Cause and EPC are 0.
- `IntReq` = 0 and `EPC` = 0.
- `DOut` follows `A1`: SR/Cause/EPC read 0, PrID reads `PRID`.

**Latencies**
- `HWInt` rising to `IntReq` high: 1 cycle, when IM, IE and ~EXL allow it.
- `HWInt` falling to `IntReq` low: 1 cycle.
- `EXLSet` to `IntReq` low: next cycle, because EXL is now set.
- `EPC` output valid: the cycle after the edge that captured it.
- `mtc0` write: visible on `DOut` and `IntReq` from the next cycle.

**Reset mid-operation**
- Asserting `reset` while EXL=1 or an interrupt is pending clears everything immediately.
- `IntReq` drops asynchronously.

## Structure

**Shared package**
- Register addresses: 12, 13, 14, 15.
- SR/Cause bit positions: IM_HI=15, IM_LO=10, EXL=1, IE=0.
- Exception vector 32'h00004180, so the next-PC logic and this block share one definition.

**Implementation**
- One flat module with no sub-module.
- One always block per register.
- Continuous assigns for `IntReq` and the `DOut` mux.

## Test plan

1. **Reset value check**: assert `reset`, then read addresses 12/13/14/15. Required: `DOut` = 0 / 0 / 0 / 32'h4D495053, and `IntReq` = 0.
2. **Interrupt raise**: `mtc0` SR = 32'h0000_0401 (IM[10], IE), then drive `HWInt` = 6'b000001. Required: `IntReq` = 1 exactly one cycle later; Cause reads 32'h0000_0400.
3. **Interrupt entry and return**: from scenario 2, pulse `EXLSet` with `PC` = 32'h0000_3017. Required: next cycle `EPC` = 32'h0000_3014, SR.EXL = 1, `IntReq` = 0. Then pulse `EXLClr` with `HWInt` still high. Required: `IntReq` = 1 the next cycle, `EPC` still 32'h0000_3014.
4. **Simultaneous events**: in one cycle, `EXLSet` + `We` (`A2`=14, `DIn`=32'hDEAD_BEEF) + `EXLClr` with `PC` = 32'h0000_3100. Required: `EPC` = 32'h0000_3100, EXL = 1.
5. **Masking and unmapped access**: `HWInt` = 6'b100000 with IM = 6'b011111. Required: `IntReq` stays 0. `mtc0` to `A2`=13 and to `A2`=7. Required: Cause reads only the IP bits, and address 7 reads 0.
6. **Asynchronous reset mid-interrupt**: assert `reset` mid-cycle while `IntReq` = 1 and EXL = 1. Required: `IntReq` and `EPC` go to 0 before the next clock edge.
